imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-memory loader that writes MIPS program words into instruction memory. It accepts decoded instruction fields (opcode, funct, register numbers, immediate, jump target) over a valid/ready stream and packs each into a 32-bit MIPS word. It writes the words to consecutive word addresses of instruction memory. It is the encoding counterpart of the main control decoder: only opcodes that decoder supports are emitted, and anything else is replaced by a NOP and flagged.

## Interface
- `ADDR_W`, 32: byte-address width of `mem_addr`.
- `LEN_W`, 16: width of the program-length field and the `count` output.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin a load; sampled only in IDLE.
- `base_addr` in ADDR_W: byte address of the first word, latched on `start`; bits [1:0] are forced to 0.
- `len` in LEN_W: number of words to load, latched on `start`.
- `abort` in 1: synchronous kill of the current load.
- `in_valid` in 1: an instruction field set is present.
- `in_ready` out 1: the loader accepts this cycle.
- `op` in 6: opcode.
- `funct` in 6: R-type function field.
- `rs`, `rt`, `rd`, `shamt` in 5 each: register fields and shift amount.
- `imm` in 16: I-type immediate.
- `target` in 26: J-type target.
- `mem_we` out 1: instruction-memory write strobe.
- `mem_addr` out ADDR_W: byte address of the write.
- `mem_wdata` out 32: encoded instruction word.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when a load completes.
- `count` out LEN_W: words written in the current or last load.
- `err` out 1: sticky illegal-opcode flag, cleared on `start`.
- `err_addr` out ADDR_W: byte address of the first illegal word in the load.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- IDLE -> RUN on `start` when `len`≠0.
- IDLE -> DONE on `start` when `len`=0.
- RUN -> DONE on the edge that performs the last write.
- DONE -> IDLE unconditionally after one cycle.
- Any state -> IDLE on `abort`. `abort` has priority over `start` and stream transfers.
- `in_ready` = (state==RUN) && (accepted<len) && !abort.
- A transfer occurs when `in_valid && in_ready`.
- Encoding by opcode:
  - `op`=0x00: R-type, {op,rs,rt,rd,shamt,funct}. Any funct is accepted.
  - `op` 0x02 (j) or 0x03 (jal): J-type, {op,target}.
  - `op` 0x01, 0x04–0x0F, 0x23 or 0x2B: I-type, {op,rs,rt,imm}.
  - Any other opcode: the word is written as 0x00000000 (NOP) at its slot. Set `err`; capture `err_addr` only if `err` was clear.
- Addresses: word i of the load goes to base_addr + 4·i, modulo 2^ADDR_W. Wrap-around is silent.
- `count` increments on each `mem_we`. It is cleared on `start` and held after DONE/abort.
- `in_valid` held while `in_ready` is low is allowed; the field set is simply not consumed.
- Reset values: state IDLE; `in_ready`, `mem_we`, `busy`, `done`, `err` = 0; `mem_addr`, `mem_wdata`, `err_addr`, `count` = 0.

## Timing
- Write latency is 1 cycle. A transfer at edge k drives `mem_we`=1 with registered `mem_addr`/`mem_wdata` during cycle k+1, for exactly one cycle per word.
- Back-to-back transfers give one write per cycle. There is no bubble at full throughput.
- Last transfer at edge k:
  - `in_ready` is low from cycle k+1.
  - The write occurs in cycle k+1.
  - State is DONE and `done`=1 in cycle k+2.
  - State is IDLE in cycle k+3.
- `len`=0: `start` at edge k gives `done`=1 in cycle k+1 with no writes.
- `abort` sampled at edge k: state is IDLE and `mem_we`=0 in cycle k+1. A word accepted at edge k is discarded. Writes completed before edge k stand. No `done` pulse.
- `start` during RUN or DONE is ignored.
- `reset` mid-load: all outputs return to their reset values immediately, asynchronously.

## Test plan
- Load with base=0x00400000, len=3: addi $t0,$zero,5 then add $t1,$t0,$t0 then j 0x100000.
  - Expect writes 0x20080005 @0x00400000, 0x01084820 @0x00400004, 0x08100000 @0x00400008.
  - Expect `done` 2 cycles after the last transfer, `count`=3, `err`=0.
- Full-throughput stream of len=8 with `in_valid` held high: expect 8 consecutive `mem_we` cycles and `in_ready` low after the 8th transfer.
- Illegal op=0x3F as word 2 of 4, base 0x1000:
  - Expect 0x00000000 written @0x1008, `err`=1, `err_addr`=0x1008.
  - Expect the remaining words still written and `count`=4.
- `abort` asserted after 2 transfers of len=5: expect exactly 2 writes, IDLE the next cycle, no `done`, `count`=2.
- Wrap-around: ADDR_W=32, base=0xFFFFFFFC, len=2 gives writes @0xFFFFFFFC and @0x00000000.
- Edge cases:
  - `len`=0 gives `done` with no writes.
  - `start` during RUN is ignored.
  - `reset` pulsed mid-load clears all outputs asynchronously.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: instruction-field stream in, instruction-memory write out.
// master = field source / memory side, slave = the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, op, funct, rs, rt, rd, shamt, imm, target,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, op, funct, rs, rt, rd, shamt, imm, target,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs decoded MIPS fields into words, writes them to imem.
// Ports: clk, reset (async high), start/base_addr/len/abort control,
// bus (stream in + mem write out), busy/done/count/err/err_addr status.
module imem_loader #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    imem_loader_if.slave      bus,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic              ready;
    logic              xfer;
    logic              load;
    logic              op_ill;
    logic [31:0]       word;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; RUN ends on the edge closing the last write cycle
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = (len == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (we_q && (acc_q == len_q)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy  = (state_q == S_RUN);
        done  = (state_q == S_DONE);
        ready = (state_q == S_RUN) && (acc_q < len_q) && !abort;
    end

    assign xfer = bus.in_valid && ready;
    assign load = start && (state_q == S_IDLE) && !abort;

    // Encoder: only opcodes the main decoder understands survive
    always_comb begin
        op_ill = 1'b0;
        word   = 32'h0;
        case (bus.op) inside
            6'h00: begin
                word = {bus.op, bus.rs, bus.rt, bus.rd,
                        bus.shamt, bus.funct};
            end
            6'h02, 6'h03: begin
                word = {bus.op, bus.target};
            end
            6'h01, [6'h04:6'h0F], 6'h23, 6'h2B: begin
                word = {bus.op, bus.rs, bus.rt, bus.imm};
            end
            default: begin
                op_ill = 1'b1;
                word   = 32'h0;
            end
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        len_d      = len_q;
        acc_d      = acc_q;
        count_d    = count_q;
        we_d       = xfer;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (load) begin
            ptr_d      = {base_addr[ADDR_W-1:2], 2'b00};
            len_d      = len;
            acc_d      = '0;
            count_d    = '0;
            err_d      = 1'b0;
            err_addr_d = '0;
        end else if (xfer) begin
            // count tracks mem_we pulses, which follow transfers 1:1
            ptr_d   = ptr_q + ADDR_W'(4);
            acc_d   = acc_q + LEN_W'(1);
            count_d = count_q + LEN_W'(1);
            addr_d  = ptr_q;
            wdata_d = word;
            if (op_ill) begin
                err_d = 1'b1;
                if (!err_q) begin
                    err_addr_d = ptr_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign count         = count_q;
    assign err           = err_q;
    assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader.
// Expected writes queued on transfer, popped when mem_we is seen.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] len;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] count;
    logic        err;
    logic [31:0] err_addr;

    imem_loader_if #(.ADDR_W(32)) bus ();

    imem_loader #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .err       (err),
        .err_addr  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    int          wr_total = 0;
    int          we_run = 0;
    logic        prev_we = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor
    always @(negedge clk) begin : mon
        logic [63:0] e;
        prev_we <= bus.mem_we;
        if (!reset && bus.mem_we) begin
            wr_total <= wr_total + 1;
            we_run   <= prev_we ? we_run + 1 : 1;
            if (sb.size() == 0) begin
                chk("unexp_we", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", {32'h0, bus.mem_addr}, {32'h0, e[63:32]});
                chk("wr_data", {32'h0, bus.mem_wdata}, {32'h0, e[31:0]});
            end
        end
    end

    function automatic logic [31:0] renc(input logic [4:0] s, t, d, sh,
                                         input logic [5:0] f);
        return {6'h00, s, t, d, sh, f};
    endfunction

    task automatic start_load(input logic [31:0] b, input logic [15:0] l);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [5:0] o, input logic [5:0] f,
                        input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh,
                        input logic [15:0] im, input logic [25:0] tg,
                        input logic [31:0] ew, input logic [31:0] ea);
        bit ok;
        ok           = 1'b0;
        bus.op       = o;
        bus.funct    = f;
        bus.rs       = s;
        bus.rt       = t;
        bus.rd       = d;
        bus.shamt    = sh;
        bus.imm      = im;
        bus.target   = tg;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back({ea, ew});
                ok = 1'b1;
            end
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", {63'h0, seen}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    int  w0;
    bit  seen_done;

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        len          = '0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.funct    = '0;
        bus.rs       = '0;
        bus.rt       = '0;
        bus.rd       = '0;
        bus.shamt    = '0;
        bus.imm      = '0;
        bus.target   = '0;
        #1;
        chk("rst_ready", {63'h0, bus.in_ready}, 64'd0);
        chk("rst_we", {63'h0, bus.mem_we}, 64'd0);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_done", {63'h0, done}, 64'd0);
        chk("rst_err", {63'h0, err}, 64'd0);
        chk("rst_addr", {32'h0, bus.mem_addr}, 64'd0);
        chk("rst_wdata", {32'h0, bus.mem_wdata}, 64'd0);
        chk("rst_erraddr", {32'h0, err_addr}, 64'd0);
        chk("rst_count", {48'h0, count}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // addi / add / j program
        start_load(32'h0040_0000, 16'd3);
        send(6'h08, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'h0,
             32'h2008_0005, 32'h0040_0000);
        send(6'h00, 6'h20, 5'd8, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0,
             32'h0108_4820, 32'h0040_0004);
        send(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10_0000,
             32'h0810_0000, 32'h0040_0008);
        chk("p1_ready_low", {63'h0, bus.in_ready}, 64'd0);
        chk("p1_done_early", {63'h0, done}, 64'd0);
        @(posedge clk);
        #1;
        chk("p1_done", {63'h0, done}, 64'd1);
        @(posedge clk);
        #1;
        chk("p1_done_drop", {63'h0, done}, 64'd0);
        chk("p1_count", {48'h0, count}, 64'd3);
        chk("p1_err", {63'h0, err}, 64'd0);

        // full throughput, len=8
        w0 = wr_total;
        start_load(32'h0000_2000, 16'd8);
        for (int i = 0; i < 8; i++) begin
            send(6'h00, 6'(6'h20 + i), 5'(i), 5'(i + 1), 5'(i + 2),
                 5'(i), 16'h0, 26'h0,
                 renc(5'(i), 5'(i + 1), 5'(i + 2), 5'(i), 6'(6'h20 + i)),
                 32'h0000_2000 + 32'(4 * i));
        end
        chk("tp_ready_low", {63'h0, bus.in_ready}, 64'd0);
        wait_done();
        chk("tp_writes", 64'(wr_total - w0), 64'd8);
        chk("tp_run", 64'(we_run), 64'd8);
        chk("tp_count", {48'h0, count}, 64'd8);

        // illegal opcode as word 2 of 4
        start_load(32'h0000_1000, 16'd4);
        send(6'h23, 6'h00, 5'd29, 5'd8, 5'd0, 5'd0, 16'd4, 26'h0,
             32'h8FA8_0004, 32'h0000_1000);
        send(6'h00, 6'h22, 5'd9, 5'd8, 5'd10, 5'd0, 16'h0, 26'h0,
             32'h0128_5022, 32'h0000_1004);
        send(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1234, 26'h0,
             32'h0000_0000, 32'h0000_1008);
        send(6'h04, 6'h00, 5'd8, 5'd9, 5'd0, 5'd0, 16'hFFFF, 26'h0,
             32'h1109_FFFF, 32'h0000_100C);
        wait_done();
        chk("ill_err", {63'h0, err}, 64'd1);
        chk("ill_erraddr", {32'h0, err_addr}, 64'h1008);
        chk("ill_count", {48'h0, count}, 64'd4);

        // opcode range edges, first illegal address sticks
        start_load(32'h0000_7000, 16'd4);
        chk("st_err_clr", {63'h0, err}, 64'd0);
        send(6'h0F, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 16'hABCD, 26'h0,
             32'h3C08_ABCD, 32'h0000_7000);
        send(6'h10, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 16'hABCD, 26'h0,
             32'h0000_0000, 32'h0000_7004);
        send(6'h2B, 6'h00, 5'd29, 5'd8, 5'd0, 5'd0, 16'd8, 26'h0,
             32'hAFA8_0008, 32'h0000_7008);
        send(6'h22, 6'h00, 5'd29, 5'd8, 5'd0, 5'd0, 16'd8, 26'h0,
             32'h0000_0000, 32'h0000_700C);
        wait_done();
        chk("rng_err", {63'h0, err}, 64'd1);
        chk("rng_erraddr", {32'h0, err_addr}, 64'h7004);

        // abort after 2 of 5
        w0 = wr_total;
        start_load(32'h0000_3000, 16'd5);
        chk("ab_err_clr", {63'h0, err}, 64'd0);
        send(6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0,
             renc(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h0000_3000);
        send(6'h00, 6'h25, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0,
             renc(5'd4, 5'd5, 5'd6, 5'd0, 6'h25), 32'h0000_3004);
        abort        = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        chk("ab_idle", {63'h0, busy}, 64'd0);
        chk("ab_we", {63'h0, bus.mem_we}, 64'd0);
        seen_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("ab_nodone", {63'h0, seen_done}, 64'd0);
        chk("ab_count", {48'h0, count}, 64'd2);
        chk("ab_writes", 64'(wr_total - w0), 64'd2);
        @(posedge clk);
        #1;

        // wrap-around, low address bits forced clear
        start_load(32'hFFFF_FFFF, 16'd2);
        send(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3,
             32'h0C00_0003, 32'hFFFF_FFFC);
        send(6'h0D, 6'h00, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0,
             32'h3401_1234, 32'h0000_0000);
        wait_done();

        // start during RUN is ignored
        start_load(32'h0000_5000, 16'd2);
        send(6'h00, 6'h00, 5'd0, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0,
             32'h0003_1100, 32'h0000_5000);
        start_load(32'h0000_9000, 16'd7);
        chk("sr_busy", {63'h0, busy}, 64'd1);
        chk("sr_count", {48'h0, count}, 64'd1);
        send(6'h01, 6'h00, 5'd5, 5'd0, 5'd0, 5'd0, 16'd8, 26'h0,
             32'h04A0_0008, 32'h0000_5004);
        wait_done();
        chk("sr_count_end", {48'h0, count}, 64'd2);

        // len = 0
        w0 = wr_total;
        start_load(32'h0000_8000, 16'd0);
        chk("l0_done", {63'h0, done}, 64'd1);
        chk("l0_busy", {63'h0, busy}, 64'd0);
        @(posedge clk);
        #1;
        chk("l0_done_drop", {63'h0, done}, 64'd0);
        chk("l0_writes", 64'(wr_total - w0), 64'd0);
        chk("l0_count", {48'h0, count}, 64'd0);

        // async reset mid-load
        start_load(32'h0000_6000, 16'd4);
        send(6'h00, 6'h20, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0,
             renc(5'd1, 5'd1, 5'd1, 5'd0, 6'h20), 32'h0000_6000);
        send(6'h00, 6'h20, 5'd2, 5'd2, 5'd2, 5'd0, 16'h0, 26'h0,
             renc(5'd2, 5'd2, 5'd2, 5'd0, 6'h20), 32'h0000_6004);
        chk("mr_we_pre", {63'h0, bus.mem_we}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        sb.delete();
        chk("mr_we", {63'h0, bus.mem_we}, 64'd0);
        chk("mr_busy", {63'h0, busy}, 64'd0);
        chk("mr_ready", {63'h0, bus.in_ready}, 64'd0);
        chk("mr_count", {48'h0, count}, 64'd0);
        chk("mr_addr", {32'h0, bus.mem_addr}, 64'd0);
        chk("mr_wdata", {32'h0, bus.mem_wdata}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
